// File: rtl/tt_uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and counter sizing.
// Reused by the transmit serializer and the future receive block.
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud.sv
// uart_baud_gen: reloadable down-counter producing a one-cycle bit_done pulse
// every CLKS_PER_BIT cycles after the most recent restart.
module uart_baud_gen
  import tt_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  // Auto-reload at zero keeps consecutive bit periods exactly CLKS_PER_BIT long.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign bit_done = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 (optional even parity) transmitter with a one-byte holding register
// and a valid/ready handshake toward the datapath.
module uart_tx_serializer
  import tt_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   hold;
  logic                   hold_full;
  logic                   par;
  logic [2:0]             bit_idx;
  logic                   bit_done;
  logic                   restart;
  logic                   accept;

  assign tx_ready = !hold_full;
  assign busy     = (state != IDLE) || hold_full;
  assign accept   = tx_valid && !hold_full;
  assign restart  = (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par       <= 1'b0;
      bit_idx   <= '0;
    end else begin
      if (accept && (state != IDLE)) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            shift <= tx_data;
            par   <= ^tx_data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN) begin
                state <= PARITY;
                tx    <= par;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          // A byte arriving on the last stop cycle with the hold empty goes
          // straight into the shifter (overriding the hold write above).
          if (bit_done) begin
            if (hold_full) begin
              shift     <= hold;
              par       <= ^hold;
              hold_full <= 1'b0;
              tx        <= 1'b0;
              state     <= START;
            end else if (accept) begin
              shift     <= tx_data;
              par       <= ^tx_data;
              hold_full <= 1'b0;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based serial waveform model.
module tb_uart_tx_serializer;

  localparam int unsigned C = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  logic [7:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic       p_tx;
  logic       p_busy;

  int pass_cnt;
  int total_cnt;
  int acc_cnt;

  // Reference model: expected line level per future cycle, plus hold occupancy.
  logic       wq[$];
  logic       m_hold;
  logic [7:0] m_hold_byte;

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         n;
    logic       etx;
    logic       erdy;
    logic       ebusy;
  } vec_t;
  vec_t vecs[$];

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid),
    .tx_ready(p_ready), .tx(p_tx), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < int'(C); j++)
        wq.push_back((i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1);
  endfunction

  // Drive inputs for one cycle, advance the model at the edge, compare mid-cycle.
  task automatic tick(input logic v, input logic [7:0] d);
    logic m_acc;
    logic exp_tx;
    tx_valid = v;
    tx_data  = d;
    if (v && tx_ready) acc_cnt++;
    @(posedge clk);
    m_acc = v && !m_hold;
    if (rst) begin
      wq.delete();
      m_hold = 1'b0;
    end else begin
      if (wq.size() > 0) void'(wq.pop_front());
      if ((wq.size() == 0) && m_hold) begin
        push_frame(m_hold_byte);
        m_hold = 1'b0;
      end
      if (m_acc) begin
        if (wq.size() == 0) push_frame(d);
        else begin
          m_hold      = 1'b1;
          m_hold_byte = d;
        end
      end
    end
    @(negedge clk);
    exp_tx = (wq.size() > 0) ? wq[0] : 1'b1;
    check("tx", 32'(tx), 32'(exp_tx));
    check("tx_ready", 32'(tx_ready), 32'(!m_hold));
    check("busy", 32'(busy), 32'((wq.size() > 0) || m_hold));
  endtask

  task automatic pframe(input logic [7:0] b, input logic exp_par);
    logic smp[1:48];
    int   nbusy;
    int   idx;
    logic e;
    nbusy = 0;
    check("p_ready_idle", 32'(p_ready), 32'd1);
    p_valid = 1'b1;
    p_data  = b;
    for (int k = 1; k <= 48; k++) begin
      tick(1'b0, 8'h00);
      p_valid = 1'b0;
      smp[k] = p_tx;
      if (p_busy) nbusy++;
      if (k <= 44) begin
        idx = (k - 1) / int'(C);
        e = (idx == 0) ? 1'b0 : (idx <= 8) ? b[idx-1] : (idx == 9) ? ^b : 1'b1;
        check("p_wave", 32'(p_tx), 32'(e));
      end
    end
    check("p_parity_bit", 32'(smp[38]), 32'(exp_par));
    check("p_frame_len", 32'(nbusy), 32'd44);
  endtask

  initial begin
    logic bb_tx[1:100];
    logic bb_rdy[1:100];
    int   nb;
    int   zeros;
    pass_cnt = 0; total_cnt = 0; acc_cnt = 0;
    m_hold = 1'b0; m_hold_byte = '0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; p_valid = 1'b0; p_data = '0;

    // Single-byte 0xA5 vector table: bits LSB first 1,0,1,0,0,1,0,1.
    vecs.push_back('{1'b1, 8'hA5, 1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b1, 1'b1, 1'b0});

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
    rst = 1'b0;

    // Reset / idle
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_ready", 32'(tx_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single byte via table
    foreach (vecs[r]) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        tick(vecs[r].v, vecs[r].d);
        check("vec_tx", 32'(tx), 32'(vecs[r].etx));
        check("vec_ready", 32'(tx_ready), 32'(vecs[r].erdy));
        check("vec_busy", 32'(busy), 32'(vecs[r].ebusy));
      end
    end

    // Back-to-back 0x00 then 0xFF
    nb = 0;
    for (int k = 1; k <= 100; k++) begin
      tick(k <= 2, (k == 1) ? 8'h00 : 8'hFF);
      bb_tx[k]  = tx;
      bb_rdy[k] = tx_ready;
      if (busy) nb++;
    end
    check("b2b_ready_low_start", 32'(bb_rdy[2]), 32'd0);
    check("b2b_ready_low_stop", 32'(bb_rdy[40]), 32'd0);
    check("b2b_ready_rise", 32'(bb_rdy[41]), 32'd1);
    check("b2b_stop_tx", 32'(bb_tx[40]), 32'd1);
    check("b2b_no_gap", 32'(bb_tx[41]), 32'd0);
    check("b2b_total_cycles", 32'(nb), 32'd80);

    // Backpressure: valid held high with fresh data each cycle
    acc_cnt = 0;
    for (int k = 0; k < 200; k++) tick(1'b1, 8'($urandom));
    check("bp_accepts", 32'(acc_cnt), 32'd6);
    for (int k = 0; k < 100; k++) tick(1'b0, 8'h00);
    check("bp_drained", 32'(busy), 32'd0);

    // Parity instance
    pframe(8'h07, 1'b1);
    pframe(8'h03, 1'b0);

    // Mid-frame reset during data bit 3 with a byte held
    tick(1'b1, 8'h5A);
    tick(1'b1, 8'h3C);
    for (int k = 3; k <= 18; k++) tick(1'b0, 8'h00);
    check("mr_hold_full", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    tick(1'b0, 8'h00);
    rst = 1'b0;
    check("mr_tx", 32'(tx), 32'd1);
    check("mr_ready", 32'(tx_ready), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    zeros = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, 8'h00);
      if (!tx) zeros++;
    end
    check("mr_no_frame", 32'(zeros), 32'd0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      tick($urandom_range(0, 3) == 0, 8'($urandom));
    end
    rst = 1'b0;
    for (int k = 0; k < 100; k++) tick(1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
